// File: rtl/div_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// div_unit
//
// Multi-cycle 32-bit integer divider for the EX stage (MIPS DIV / DIVU).
// Restoring division, one quotient bit per clock, 32 iterations sequenced by
// the external EX stall counter. Quotient goes to LO, remainder goes to HI.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor is caught at start and the unit jumps straight
//               to FIX (Q=0xFFFFFFFF, R=dividend, div_by_zero_o=1).
//   undefined : no detection; div_by_zero_o is tied to 0.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active low
//   div_i            start request (sampled only while ready_o=1)
//   signed_i         1 = DIV, 0 = DIVU (sampled with div_i)
//   dividend_i       rs operand
//   divisor_i        rt operand
//   stall_counter_i  remaining-iteration count from the EX stall counter
//   div_stall_o      high in BUSY; decrements the stall counter
//   stall_complete_o high in IDLE and FIX; reloads the stall counter to 32
//   ready_o          IDLE and stall counter back at 32
//   done_o           one-cycle pulse, results valid from this cycle
//   quotient_o       LO result, held until the next completion
//   remainder_o      HI result, held until the next completion
//   div_by_zero_o    divisor was zero, held with the results
// ---------------------------------------------------------------------------
module div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        div_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [31:0] stall_counter_i,
  output logic        div_stall_o,
  output logic        stall_complete_o,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        div_by_zero_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  // r_dvd holds the shifting dividend; quotient bits enter at the LSB, so
  // after 32 iterations it holds the unsigned quotient.
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_rem;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div_stall;
  logic        r_stall_complete;

  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [31:0] w_dvd_abs;
  logic [31:0] w_dvs_abs;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic        w_start;
  logic        w_last;
  logic        w_fault;

  assign w_dvd_neg = signed_i & dividend_i[31];
  assign w_dvs_neg = signed_i & divisor_i[31];
  assign w_dvd_abs = w_dvd_neg ? (32'd0 - dividend_i) : dividend_i;
  assign w_dvs_abs = w_dvs_neg ? (32'd0 - divisor_i)  : divisor_i;

  // Shifted partial remainder keeps the old MSB so that a DIVU divisor with
  // bit 31 set still compares correctly.
  assign w_shift = {r_rem, r_dvd[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  // When w_ge holds the difference is below the divisor, so 32 bits suffice.
  assign w_diff  = w_shift[31:0] - r_dvs;

  assign ready_o = (r_state == S_IDLE) && (stall_counter_i == 32'd32);
  assign w_start = div_i & ready_o;
  assign w_last  = (stall_counter_i == 32'd1);
  assign w_fault = (stall_counter_i == 32'd0) || (stall_counter_i > 32'd32);

  assign div_stall_o      = r_div_stall;
  assign stall_complete_o = r_stall_complete;

`ifdef DIV_ZERO_DETECT_EN
  logic r_dz;
  logic r_div_by_zero;
  assign div_by_zero_o = r_div_by_zero;
`else
  assign div_by_zero_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state          <= S_IDLE;
      r_dvd            <= 32'd0;
      r_dvs            <= 32'd0;
      r_rem            <= 32'd0;
      r_neg_q          <= 1'b0;
      r_neg_r          <= 1'b0;
      r_div_stall      <= 1'b0;
      r_stall_complete <= 1'b1;
      done_o           <= 1'b0;
      quotient_o       <= 32'd0;
      remainder_o      <= 32'd0;
`ifdef DIV_ZERO_DETECT_EN
      r_dz             <= 1'b0;
      r_div_by_zero    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
`ifdef DIV_ZERO_DETECT_EN
            if (divisor_i == 32'd0) begin
              // Preload the registers so FIX emits Q=all ones, R=dividend.
              r_dvd            <= 32'hFFFF_FFFF;
              r_dvs            <= 32'd0;
              r_rem            <= dividend_i;
              r_neg_q          <= 1'b0;
              r_neg_r          <= 1'b0;
              r_dz             <= 1'b1;
              r_state          <= S_FIX;
              r_div_stall      <= 1'b0;
              r_stall_complete <= 1'b1;
            end else begin
              r_dvd            <= w_dvd_abs;
              r_dvs            <= w_dvs_abs;
              r_rem            <= 32'd0;
              r_neg_q          <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r          <= w_dvd_neg;
              r_dz             <= 1'b0;
              r_state          <= S_BUSY;
              r_div_stall      <= 1'b1;
              r_stall_complete <= 1'b0;
            end
`else
            r_dvd            <= w_dvd_abs;
            r_dvs            <= w_dvs_abs;
            r_rem            <= 32'd0;
            r_neg_q          <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r          <= w_dvd_neg;
            r_state          <= S_BUSY;
            r_div_stall      <= 1'b1;
            r_stall_complete <= 1'b0;
`endif
          end
        end

        S_BUSY: begin
          if (w_fault) begin
            // Counter out of range: abandon iteration, let FIX return to IDLE.
            r_state          <= S_FIX;
            r_div_stall      <= 1'b0;
            r_stall_complete <= 1'b1;
          end else begin
            if (w_ge) begin
              r_rem <= w_diff;
              r_dvd <= {r_dvd[30:0], 1'b1};
            end else begin
              r_rem <= w_shift[31:0];
              r_dvd <= {r_dvd[30:0], 1'b0};
            end
            if (w_last) begin
              r_state          <= S_FIX;
              r_div_stall      <= 1'b0;
              r_stall_complete <= 1'b1;
            end
          end
        end

        S_FIX: begin
          quotient_o       <= r_neg_q ? (32'd0 - r_dvd) : r_dvd;
          remainder_o      <= r_neg_r ? (32'd0 - r_rem) : r_rem;
          done_o           <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          r_div_by_zero    <= r_dz;
`endif
          r_state          <= S_IDLE;
          r_div_stall      <= 1'b0;
          r_stall_complete <= 1'b1;
        end

        default: begin
          r_state          <= S_IDLE;
          r_div_stall      <= 1'b0;
          r_stall_complete <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
// Directed bench for div_unit. Includes a behavioural EX stall counter that
// reloads to 32 on stall_complete_o and decrements on div_stall_o.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        div_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [31:0] stall_counter_i;
  logic        div_stall_o;
  logic        stall_complete_o;
  logic        ready_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_by_zero_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  div_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .div_i            (div_i),
    .signed_i         (signed_i),
    .dividend_i       (dividend_i),
    .divisor_i        (divisor_i),
    .stall_counter_i  (stall_counter_i),
    .div_stall_o      (div_stall_o),
    .stall_complete_o (stall_complete_o),
    .ready_o          (ready_o),
    .done_o           (done_o),
    .quotient_o       (quotient_o),
    .remainder_o      (remainder_o),
    .div_by_zero_o    (div_by_zero_o)
  );

  // EX stall counter
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                stall_counter_i <= 32'd0;
    else if (stall_complete_o) stall_counter_i <= 32'd32;
    else if (div_stall_o)      stall_counter_i <= stall_counter_i - 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ready_o at a falling edge, then presents one request
  // across a single rising edge (edge 0).
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    chk("issue_ready", {31'd0, ready_o}, 32'd1);
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    div_i      = 1'b1;
    @(posedge clk_i);
    #1 div_i = 1'b0;
  endtask

  // Returns at the falling edge of the done_o cycle; lat is that cycle number.
  task automatic wait_done(output int lat, output int stalls);
    int overlap;
    lat     = 0;
    stalls  = 0;
    overlap = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk_i);
      if (div_stall_o) stalls++;
      if (div_stall_o && stall_complete_o) overlap++;
      if (done_o) begin
        lat = c;
        break;
      end
    end
    chk("stall_complete_overlap", overlap, 0);
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                     input logic edz, input int elat, input int estalls);
    int lat;
    int stalls;
    issue(sgn, a, b);
    wait_done(lat, stalls);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_stalls"}, stalls, estalls);
    chk({tag, "_q"}, quotient_o, eq);
    chk({tag, "_r"}, remainder_o, er);
    chk({tag, "_dz"}, {31'd0, div_by_zero_o}, {31'd0, edz});
    $display("txn %s: sgn=%0d a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h dz=%0d lat=%0d stalls=%0d",
             tag, sgn, a, b, quotient_o, remainder_o, div_by_zero_o, lat, stalls);
  endtask

  initial begin
    rst_i      = 1'b0;
    div_i      = 1'b0;
    signed_i   = 1'b0;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_div_stall", {31'd0, div_stall_o}, 32'd0);
    chk("rst_stall_complete", {31'd0, stall_complete_o}, 32'd1);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_q", quotient_o, 32'd0);
    chk("rst_r", remainder_o, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);

    rst_i = 1'b1;
    #1 chk("release_ready_low", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    chk("release_ready_high", {31'd0, ready_o}, 32'd1);

    // DIVU 100 / 7
    run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 32);
    @(negedge clk_i);
    chk("done_single_pulse", {31'd0, done_o}, 32'd0);
    chk("q_held", quotient_o, 32'd14);

    // Signed cases
    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 32);
    run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 32);
    run("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 32);

    // Back-to-back: second request presented in the first done_o cycle
    run("b2b_first", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 34, 32);
    run("b2b_second", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 32);

    // Reset in BUSY cycle 10
    issue(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk_i);
    chk("midrst_busy_before", {31'd0, div_stall_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("midrst_div_stall", {31'd0, div_stall_o}, 32'd0);
    chk("midrst_stall_complete", {31'd0, stall_complete_o}, 32'd1);
    chk("midrst_q", quotient_o, 32'd0);
    chk("midrst_r", remainder_o, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_dz", {31'd0, div_by_zero_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1 chk("midrst_ready_low", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    chk("midrst_ready_high", {31'd0, ready_o}, 32'd1);
    chk("midrst_no_done", {31'd0, done_o}, 32'd0);
    $display("txn midrst: reset applied in BUSY cycle 10, released after 2 cycles");
    run("divu_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34, 32);

    // Zero divisor
`ifdef DIV_ZERO_DETECT_EN
    run("divu_1234_0", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 2, 0);
`else
    run("divu_1234_0", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b0, 34, 32);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
